// File: rtl/stream_buffer_control.sv
// Sequencing controller for the single-entry L2-to-pmem stream write buffer.
// Owns the buffer valid bit and line tag and drives the L2 response and pmem handshake.
`timescale 1ns/1ps
module stream_buffer_control #(
  parameter int OFFSET_BITS       = 5,
  parameter int DRAIN_IDLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  output logic        resp,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp,
  output logic        buf_load,
  output logic        rdata_sel,
  output logic        buf_valid
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FETCH} state_e;

  localparam int CNT_W = (DRAIN_IDLE_CYCLES > 0) ? $clog2(DRAIN_IDLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'((DRAIN_IDLE_CYCLES > 0) ? DRAIN_IDLE_CYCLES - 1 : 0);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & LINE_MASK;
  endfunction

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [31:0]      tag_q, tag_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [31:0] req_line;
  logic        hit;

  assign req_line  = line_of(address);
  assign hit       = valid_q && (tag_q == req_line);
  assign buf_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    idle_cnt_d   = idle_cnt_q;
    resp         = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    buf_load     = 1'b0;
    rdata_sel    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Read takes priority so an illegal read+write never corrupts the buffer.
        if (read) begin
          idle_cnt_d = '0;
          if (hit) begin
            resp      = 1'b1;
            rdata_sel = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else if (write) begin
          idle_cnt_d = '0;
          if (!valid_q || hit) begin
            resp     = 1'b1;
            buf_load = 1'b1;
            tag_d    = req_line;
            valid_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (valid_q) begin
          if (idle_cnt_q != CNT_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
          if ((DRAIN_IDLE_CYCLES != 0) && (idle_cnt_q == CNT_FIRE)) begin
            state_d = S_DRAIN;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      S_DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = tag_q;
        if (pmem_resp) begin
          valid_d    = 1'b0;
          idle_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end

      S_FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = req_line;
        if (pmem_resp) begin
          resp    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_buffer_control.sv
// Self-checking bench for stream_buffer_control: directed scenarios plus a
// randomized request stream checked against a transaction-level buffer model.
`timescale 1ns/1ps
module tb_stream_buffer_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        pmem_resp = 1'b0;
  logic        resp, pmem_read, pmem_write, buf_load, rdata_sel, buf_valid;
  logic [31:0] pmem_address;

  int n_checks = 0;
  int n_fail   = 0;
  bit auto_pmem = 1'b0;
  bit mon_on    = 1'b0;

  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];

  stream_buffer_control #(
    .OFFSET_BITS(5),
    .DRAIN_IDLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .read(read),
    .write(write),
    .resp(resp),
    .pmem_address(pmem_address),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_resp(pmem_resp),
    .buf_load(buf_load),
    .rdata_sel(rdata_sel),
    .buf_valid(buf_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Random-latency pmem responder, active only during the randomized phase.
  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = 1;
    forever begin
      @(posedge clk);
      #2;
      if (auto_pmem) begin
        if (pmem_read || pmem_write) begin
          if (cnt >= lat) begin
            pmem_resp = 1'b1;
            cnt = 0;
            lat = $urandom_range(0, 3);
          end else begin
            pmem_resp = 1'b0;
            cnt++;
          end
        end else begin
          pmem_resp = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // Logs completed pmem transactions and checks per-cycle output invariants.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        n_checks++;
        if ((pmem_read && pmem_write) || (buf_load && !resp) || (pmem_address[4:0] != 5'd0)) begin
          n_fail++;
          $display("FAIL invariant: pmem_read=%0b pmem_write=%0b buf_load=%0b resp=%0b addr=%h (required: not both pmem, buf_load only with resp, aligned addr)",
                   pmem_read, pmem_write, buf_load, resp, pmem_address);
        end
        if ((pmem_read || pmem_write) && pmem_resp) obs_q.push_back({pmem_write, pmem_address});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    logic [37:0] got;
    rst_n = 1'b0;
    read = 1'b0; write = 1'b0; address = 32'h0; pmem_resp = 1'b0;
    repeat (3) cyc();
    smp();
    got = {resp, pmem_read, pmem_write, buf_load, rdata_sel, buf_valid, pmem_address};
    n_checks++;
    if (got !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", got);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_write();
    cyc(); address = 32'h0000_1044; write = 1'b1;
    smp();
    n_checks++;
    if ({resp, buf_load, pmem_read, pmem_write} !== 4'b1100) begin
      n_fail++;
      $display("FAIL first_write_resp: resp/load/prd/pwr got %b required 1100", {resp, buf_load, pmem_read, pmem_write});
    end
    cyc(); write = 1'b0;
    smp();
    n_checks++;
    if (buf_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_write_valid: buf_valid got %b required 1", buf_valid);
    end
  endtask

  task automatic test_read_hit();
    cyc(); address = 32'h0000_105C; read = 1'b1;
    smp();
    n_checks++;
    if ({resp, rdata_sel, pmem_read, pmem_write} !== 4'b1100) begin
      n_fail++;
      $display("FAIL read_hit: resp/sel/prd/pwr got %b required 1100", {resp, rdata_sel, pmem_read, pmem_write});
    end
    cyc(); read = 1'b0;
  endtask

  task automatic test_read_miss();
    logic [34:0] want;
    cyc(); address = 32'h0000_2000; read = 1'b1;
    smp();
    n_checks++;
    if ({resp, pmem_read} !== 2'b00) begin
      n_fail++;
      $display("FAIL read_miss_first: resp/prd got %b required 00", {resp, pmem_read});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); pmem_resp = (i == 2);
      smp();
      want = {1'b1, 1'b0, (i == 2), 32'h0000_2000};
      n_checks++;
      if ({pmem_read, pmem_write, resp, pmem_address} !== want) begin
        n_fail++;
        $display("FAIL read_miss_fetch%0d: got %h required %h", i, {pmem_read, pmem_write, resp, pmem_address}, want);
      end
    end
    cyc(); read = 1'b0; pmem_resp = 1'b0;
    smp();
    n_checks++;
    if ({buf_valid, pmem_read} !== 2'b10) begin
      n_fail++;
      $display("FAIL read_miss_after: valid/prd got %b required 10", {buf_valid, pmem_read});
    end
  endtask

  task automatic test_write_conflict();
    logic [34:0] want;
    cyc(); address = 32'h0000_3000; write = 1'b1;
    smp();
    n_checks++;
    if ({resp, buf_load, pmem_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL conflict_first: resp/load/pwr got %b required 000", {resp, buf_load, pmem_write});
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); pmem_resp = (i == 1);
      smp();
      want = {1'b1, 1'b0, 1'b0, 32'h0000_1040};
      n_checks++;
      if ({pmem_write, pmem_read, resp, pmem_address} !== want) begin
        n_fail++;
        $display("FAIL conflict_drain%0d: got %h required %h", i, {pmem_write, pmem_read, resp, pmem_address}, want);
      end
    end
    cyc(); pmem_resp = 1'b0;
    smp();
    n_checks++;
    if ({resp, buf_load, pmem_write, buf_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL conflict_absorb: resp/load/pwr/valid got %b required 1100", {resp, buf_load, pmem_write, buf_valid});
    end
    cyc(); write = 1'b0;
    smp();
    n_checks++;
    if (buf_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_valid: buf_valid got %b required 1", buf_valid);
    end
    cyc(); address = 32'h0000_301F; read = 1'b1;
    smp();
    n_checks++;
    if ({resp, rdata_sel, pmem_read} !== 3'b110) begin
      n_fail++;
      $display("FAIL conflict_newtag: resp/sel/prd got %b required 110", {resp, rdata_sel, pmem_read});
    end
  endtask

  task automatic test_idle_drain();
    bit early;
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); read = 1'b0; write = 1'b0;
      smp();
      early |= pmem_write;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_drain_early: pmem_write got 1 within 4 idle cycles required 0");
    end
    cyc(); smp();
    n_checks++;
    if ({pmem_write, pmem_address} !== {1'b1, 32'h0000_3000}) begin
      n_fail++;
      $display("FAIL idle_drain_start: got %h required %h", {pmem_write, pmem_address}, {1'b1, 32'h0000_3000});
    end
    cyc(); pmem_resp = 1'b1; smp();
    cyc(); pmem_resp = 1'b0; smp();
    n_checks++;
    if ({buf_valid, pmem_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_drain_done: valid/pwr got %b required 00", {buf_valid, pmem_write});
    end
    cyc(); address = 32'h0000_4000; write = 1'b1;
    smp();
    for (int i = 0; i < 3; i++) begin
      cyc(); write = 1'b0; smp();
    end
    cyc(); address = 32'h0000_4008; read = 1'b1;
    smp();
    n_checks++;
    if ({resp, rdata_sel, pmem_write} !== 3'b110) begin
      n_fail++;
      $display("FAIL idle_restart_hit: resp/sel/pwr got %b required 110", {resp, rdata_sel, pmem_write});
    end
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); read = 1'b0; smp();
      early |= pmem_write;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_restart_early: pmem_write got 1 after count reset required 0");
    end
    cyc(); smp();
    n_checks++;
    if ({pmem_write, pmem_address} !== {1'b1, 32'h0000_4000}) begin
      n_fail++;
      $display("FAIL idle_restart_drain: got %h required %h", {pmem_write, pmem_address}, {1'b1, 32'h0000_4000});
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [37:0] got;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pmem_write, buf_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_drain: pwr/valid got %b required 00", {pmem_write, buf_valid});
    end
    cyc(); cyc();
    smp();
    rst_n = 1'b1;
    cyc(); smp();
    got = {resp, pmem_read, pmem_write, buf_load, rdata_sel, buf_valid, pmem_address};
    n_checks++;
    if (got !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h required 0", got);
    end
    cyc(); address = 32'h0000_5000; write = 1'b1;
    smp();
    n_checks++;
    if ({resp, buf_load, pmem_write} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release_write: resp/load/pwr got %b required 110", {resp, buf_load, pmem_write});
    end
    cyc(); write = 1'b0;
  endtask

  task automatic test_rw_illegal();
    logic [35:0] want;
    cyc(); address = 32'h0000_6000; read = 1'b1; write = 1'b1;
    $display("note: driving illegal simultaneous read and write, expecting read behaviour");
    smp();
    n_checks++;
    if ({resp, buf_load} !== 2'b00) begin
      n_fail++;
      $display("FAIL rw_first: resp/load got %b required 00", {resp, buf_load});
    end
    cyc(); pmem_resp = 1'b1;
    smp();
    want = {1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_6000};
    n_checks++;
    if ({pmem_read, pmem_write, resp, buf_load, pmem_address} !== want) begin
      n_fail++;
      $display("FAIL rw_fetch: got %h required %h", {pmem_read, pmem_write, resp, buf_load, pmem_address}, want);
    end
    cyc(); read = 1'b0; write = 1'b0; pmem_resp = 1'b0;
    cyc(); address = 32'h0000_5004; read = 1'b1;
    smp();
    n_checks++;
    if ({resp, rdata_sel} !== 2'b11) begin
      n_fail++;
      $display("FAIL rw_buffer_kept: resp/sel got %b required 11", {resp, rdata_sel});
    end
    cyc(); read = 1'b0;
  endtask

  task automatic do_req(input bit isw, input logic [31:0] a, output int lat,
                        output bit got_load, output bit got_sel, output bit ok);
    cyc(); address = a; read = !isw; write = isw;
    lat = 0; ok = 1'b0; got_load = 1'b0; got_sel = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      smp();
      if (resp) begin
        ok = 1'b1;
        got_load = buf_load;
        got_sel = rdata_sel;
      end else begin
        lat++;
        cyc();
      end
    end
  endtask

  task automatic test_random();
    bit          mvalid;
    logic [31:0] mtag;
    logic [31:0] a;
    bit          isw, hit, drained, fast, gl, gs, ok;
    int          g, lat;
    rst_n = 1'b0;
    read = 1'b0; write = 1'b0; pmem_resp = 1'b0;
    cyc(); cyc(); smp();
    rst_n = 1'b1;
    mvalid = 1'b0; mtag = '0;
    exp_q.delete(); obs_q.delete();
    auto_pmem = 1'b1;
    mon_on = 1'b1;
    for (int it = 0; it < 60; it++) begin
      g = $urandom_range(0, 6);
      for (int i = 0; i < g; i++) begin
        cyc(); read = 1'b0; write = 1'b0;
        smp();
        if (i == 0) begin
          n_checks++;
          if (buf_valid !== mvalid) begin
            n_fail++;
            $display("FAIL rand_valid it%0d: buf_valid got %b required %b", it, buf_valid, mvalid);
          end
        end
      end
      drained = 1'b0;
      if (mvalid && g >= 4) begin
        exp_q.push_back({1'b1, mtag});
        mvalid = 1'b0;
        drained = 1'b1;
      end
      isw = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(1, 3)) << 12;
      a = a | ($urandom & 32'h1F);
      if ($urandom_range(0, 7) == 0) a = a | 32'hA000_0000;
      hit = mvalid && (mtag == line_of(a));
      if (!isw) begin
        if (!hit) exp_q.push_back({1'b0, line_of(a)});
        fast = hit;
      end else begin
        if (mvalid && !hit) exp_q.push_back({1'b1, mtag});
        fast = !mvalid || hit;
        mtag = line_of(a);
        mvalid = 1'b1;
      end
      do_req(isw, a, lat, gl, gs, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_timeout it%0d: no resp within 40 cycles required resp", it);
      end else begin
        n_checks++;
        if (gl !== isw) begin
          n_fail++;
          $display("FAIL rand_buf_load it%0d: got %b required %b", it, gl, isw);
        end
        n_checks++;
        if (gs !== (!isw && hit)) begin
          n_fail++;
          $display("FAIL rand_rdata_sel it%0d: got %b required %b", it, gs, (!isw && hit));
        end
        if (!drained) begin
          n_checks++;
          if ((lat == 0) !== fast) begin
            n_fail++;
            $display("FAIL rand_latency it%0d: latency %0d zero-latency required %b", it, lat, fast);
          end
        end
      end
      #1;
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand_pmem_count it%0d: got %0d pmem ops required %0d", it, obs_q.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          n_checks++;
          if (obs_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL rand_pmem_op it%0d.%0d: got %h required %h", it, k, obs_q[k], exp_q[k]);
          end
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
    cyc(); read = 1'b0; write = 1'b0;
    mon_on = 1'b0;
    auto_pmem = 1'b0;
    pmem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_read_hit();
    test_read_miss();
    test_write_conflict();
    test_idle_drain();
    test_reset_mid_drain();
    test_rw_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
